irq_controller: RTL and testbench



---
 rtl/irq_controller.sv | 125 ++++++++++++
 tb/tb_irq_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller: latches up to NUM_SRC edge- or level-triggered sources, masks
// them, and raises one registered request to the core. Its registers are
// accessed over the picorv32 valid/ready slave bus.

// Capture cell for one source. It remembers last cycle's input so edge mode can
// detect a rise. The history register is loaded every cycle, including during
// reset, so a source that is already high when reset is released is not seen
// as a new edge.
module irqc_src_cell (
  input  logic clk,
  input  logic src,
  input  logic edge_mode,
  output logic set
);
  logic src_prev;

  // input history, deliberately not reset
  always_ff @(posedge clk) src_prev <= src;

  assign set = edge_mode ? (src & ~src_prev) : src;
endmodule

module irq_controller #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               irqc_sel,
  input  logic [4:0]         addr,
  input  logic [3:0]         wstrb,
  input  logic [31:0]        irqc_data_i,
  output logic               irqc_ready,
  output logic [31:0]        irqc_data_o,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               cpu_irq
);
  typedef enum logic [2:0] {
    REG_PENDING = 3'd0,
    REG_ENABLE  = 3'd1,
    REG_MODE    = 3'd2,
    REG_STATUS  = 3'd3,
    REG_SWSET   = 3'd4
  } reg_e;

  logic [NUM_SRC-1:0] pending, enable, mode;
  logic [NUM_SRC-1:0] set_vec, clr_vec, swset_vec;
  logic [NUM_SRC-1:0] lane_m, wdata_m;
  logic [31:0]        lane_mask, rdata;
  logic               accept, wr, rd;
  reg_e               word;
  logic               unused_bits;

  // A transaction is taken only on the first cycle of select. The ready pulse
  // that follows blocks it from being accepted a second time.
  assign accept = irqc_sel & ~irqc_ready;
  assign wr     = accept & (|wstrb);
  assign rd     = accept & ~(|wstrb);
  assign word   = reg_e'(addr[4:2]);

  // Expand the byte strobes to a bit mask. Bits at or above NUM_SRC drop out here.
  assign lane_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign lane_m    = lane_mask[NUM_SRC-1:0];
  assign wdata_m   = irqc_data_i[NUM_SRC-1:0] & lane_m;

  // Address bits [1:0], and the data or strobe bits above NUM_SRC, have no effect.
  assign unused_bits = ^{addr[1:0], irqc_data_i, lane_mask};

  irqc_src_cell u_src [NUM_SRC-1:0] (
    .clk       (clk),
    .src       (irq_src),
    .edge_mode (mode),
    .set       (set_vec)
  );

  // Bus-driven clear and set strobes for the pending register
  always_comb begin
    clr_vec   = '0;
    swset_vec = '0;
    if (wr) begin
      case (word)
        REG_PENDING: clr_vec   = wdata_m;
        REG_SWSET:   swset_vec = wdata_m;
        default: ;
      endcase
    end
  end

  // Register state. The set terms come last, so a still-asserted source wins over a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec | swset_vec;
      if (wr && word == REG_ENABLE) enable <= (enable & ~lane_m) | wdata_m;
      if (wr && word == REG_MODE)   mode   <= (mode & ~lane_m) | wdata_m;
    end
  end

  // Read mux. Unimplemented offsets and SWSET read as zero.
  always_comb begin
    rdata = '0;
    case (word)
      REG_PENDING: rdata = 32'(pending);
      REG_ENABLE:  rdata = 32'(enable);
      REG_MODE:    rdata = 32'(mode);
      REG_STATUS:  rdata = 32'(pending & enable);
      default:     rdata = '0;
    endcase
  end

  // Handshake, registered read data and the interrupt request
  always_ff @(posedge clk) begin
    if (reset) begin
      irqc_ready  <= 1'b0;
      irqc_data_o <= '0;
      cpu_irq     <= 1'b0;
    end else begin
      irqc_ready <= irqc_sel & ~irqc_ready;
      if (rd) irqc_data_o <= rdata;
      cpu_irq <= |(pending & enable);
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller. It uses hand-computed vectors and drives
// the bus the way picorv32 does: select is held until ready is seen.
module tb_irq_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic        irqc_sel;
  logic [4:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] irqc_data_i;
  logic        irqc_ready;
  logic [31:0] irqc_data_o;
  logic [7:0]  irq_src;
  logic        cpu_irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rv;
  logic        irq_at_e;

  irq_controller #(.NUM_SRC(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .irqc_sel    (irqc_sel),
    .addr        (addr),
    .wstrb       (wstrb),
    .irqc_data_i (irqc_data_i),
    .irqc_ready  (irqc_ready),
    .irqc_data_o (irqc_data_o),
    .irq_src     (irq_src),
    .cpu_irq     (cpu_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge. Sampling and driving happen 1ns after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One bus transaction. The accept edge is E, and the task returns after E+1.
  task automatic xfer(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] r);
    irqc_sel = 1'b1; addr = a; wstrb = s; irqc_data_i = d;
    tick;
    chk("ready_pulse", 32'(irqc_ready), 32'd1);
    r = irqc_data_o;
    irq_at_e = cpu_irq;
    irqc_sel = 1'b0; wstrb = 4'h0; irqc_data_i = '0;
    tick;
    chk("ready_drop", 32'(irqc_ready), 32'd0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] dummy;
    xfer(a, s, d, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] r;
    xfer(a, 4'h0, 32'h0, r);
    chk(tag, r, exp);
  endtask

  initial begin
    reset = 1'b1; irqc_sel = 1'b0; addr = '0; wstrb = '0; irqc_data_i = '0;
    irq_src = 8'h01;
    irq_at_e = 1'b0;
    #1;

    // reset, with source 0 already high
    repeat (3) tick;
    chk("rst_ready", 32'(irqc_ready), 32'd0);
    chk("rst_data",  irqc_data_o, 32'd0);
    chk("rst_irq",   32'(cpu_irq), 32'd0);
    reset = 1'b0; irq_src = 8'h00;
    tick;
    rd_chk("rst_pending", 5'h00, 32'h0);
    rd_chk("rst_enable",  5'h04, 32'h0);

    // edge mode
    wr(5'h04, 32'h01);
    wr(5'h08, 32'h01);
    irq_src = 8'h01;
    tick;                               // sample edge E
    irq_src = 8'h00;
    chk("edge_irq_e", 32'(cpu_irq), 32'd0);
    tick;                               // E+1
    chk("edge_irq_e1", 32'(cpu_irq), 32'd1);
    rd_chk("edge_pending", 5'h00, 32'h01);
    wr(5'h00, 32'h01);
    chk("clr_irq_at_e", 32'(irq_at_e), 32'd1);
    chk("clr_irq_e1", 32'(cpu_irq), 32'd0);
    rd_chk("clr_pending", 5'h00, 32'h0);
    // a source held high in edge mode latches only once
    irq_src = 8'h01;
    tick; tick;
    wr(5'h00, 32'h01);
    rd_chk("edge_hold", 5'h00, 32'h0);
    irq_src = 8'h00;
    tick;

    // level mode
    wr(5'h08, 32'h00);
    wr(5'h04, 32'h04);
    irq_src = 8'h04;
    tick;
    wr(5'h00, 32'h04);
    rd_chk("lvl_noclr", 5'h00, 32'h04);
    chk("lvl_irq", 32'(cpu_irq), 32'd1);
    // switching to edge mode while the source is high creates no new edge
    wr(5'h08, 32'h04);
    irq_src = 8'h00;
    tick;
    wr(5'h00, 32'h04);
    rd_chk("lvl_clr", 5'h00, 32'h0);
    chk("lvl_irq_low", 32'(cpu_irq), 32'd0);

    // masking
    wr(5'h04, 32'h00);
    wr(5'h08, 32'h20);
    rd_chk("mode_rb", 5'h08, 32'h20);
    irq_src = 8'h20;
    tick;
    irq_src = 8'h00;
    tick;
    rd_chk("mask_pending", 5'h00, 32'h20);
    rd_chk("mask_status",  5'h0C, 32'h0);
    chk("mask_irq", 32'(cpu_irq), 32'd0);
    wr(5'h04, 32'h20);
    chk("en_irq_at_e", 32'(irq_at_e), 32'd0);
    chk("en_irq_e1", 32'(cpu_irq), 32'd1);
    rd_chk("en_status", 5'h0C, 32'h20);

    // byte lanes, SWSET and unused offsets
    wr(5'h00, 32'hFF);
    rd_chk("sw_pre", 5'h00, 32'h0);
    wr(5'h10, 32'h0000_0180, 4'b0001);
    rd_chk("sw_pending", 5'h00, 32'h80);
    rd_chk("sw_read0", 5'h10, 32'h0);
    rd_chk("off18", 5'h18, 32'h0);
    wr(5'h04, 32'hFFFF_FFFF);
    rd_chk("en_width", 5'h04, 32'hFF);
    wr(5'h04, 32'h0000_0000, 4'b0010);
    rd_chk("en_lane", 5'h04, 32'hFF);
    wr(5'h1C, 32'hFFFF_FFFF);
    rd_chk("status_all", 5'h0C, 32'h80);
    chk("sw_irq", 32'(cpu_irq), 32'd1);

    // handshake with select held high
    irqc_sel = 1'b1; addr = 5'h04; wstrb = 4'h0;
    chk("hs_pre", 32'(irqc_ready), 32'd0);
    tick;
    chk("hs_rdy1", 32'(irqc_ready), 32'd1);
    chk("hs_data", irqc_data_o, 32'hFF);
    tick;
    chk("hs_rdy0", 32'(irqc_ready), 32'd0);
    tick;
    chk("hs_repeat", 32'(irqc_ready), 32'd1);
    reset = 1'b1;
    tick;
    chk("hs_rst_rdy", 32'(irqc_ready), 32'd0);
    chk("hs_rst_irq", 32'(cpu_irq), 32'd0);
    chk("hs_rst_data", irqc_data_o, 32'd0);
    reset = 1'b0; irqc_sel = 1'b0;
    tick;
    rd_chk("post_rst_en", 5'h04, 32'h0);
    rd_chk("post_rst_pend", 5'h00, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
